// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared types and compare helper for the popcount matcher
package popcount_pkg;

    typedef enum logic [1:0] {
        MODE_EQ  = 2'b00,
        MODE_GE  = 2'b01,
        MODE_LE  = 2'b10,
        MODE_ODD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Operands are zero-extended by the caller, so all compares are unsigned.
    function automatic logic match_f(input logic [31:0] count,
                                     input logic [31:0] target,
                                     input mode_e       mode);
        logic m;
        case (mode)
            MODE_EQ:  m = (count == target);
            MODE_GE:  m = (count >= target);
            MODE_LE:  m = (count <= target);
            default:  m = count[0];
        endcase
        return m;
    endfunction

endpackage

// File: rtl/popcount_slice.sv
// rtl/popcount_slice.sv - combinational ones-count of one CHUNK-bit slice
module popcount_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]           data,
    output logic [$clog2(CHUNK+1)-1:0] cnt
);

    localparam int SW = $clog2(CHUNK + 1);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt = cnt + SW'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_matcher.sv
// rtl/popcount_matcher.sv - sequential ones-counter with threshold compare and valid/ready flow control
module popcount_matcher
    import popcount_pkg::*;
#(
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic [$clog2(W+1)-1:0]   in_target,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(W+1)-1:0]   out_count,
    output logic                     out_match
);

    localparam int NCH = W / CHUNK;
    localparam int CW  = $clog2(W + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW  = $clog2(CHUNK + 1);

    generate
        if (W < 1 || CHUNK < 1 || (W % CHUNK) != 0) begin : g_bad_params
            $error("popcount_matcher: W must be a positive multiple of CHUNK");
        end
    endgenerate

    state_e          state_q, state_d;
    logic [W-1:0]    data_q;
    logic [CW-1:0]   target_q;
    mode_e           mode_q;
    logic [CW-1:0]   acc_q;
    logic [IW-1:0]   idx_q;

    logic [W-1:0]    shifted;
    logic [CHUNK-1:0] slice;
    logic [SW-1:0]   slice_cnt;
    logic [CW-1:0]   acc_next;
    logic            last_slice;
    logic            accept;

    // Shift rather than indexed part-select keeps the selection legal when NCH == 1.
    assign shifted    = data_q >> (CHUNK * 32'(idx_q));
    assign slice      = shifted[CHUNK-1:0];
    assign acc_next   = acc_q + CW'(slice_cnt);
    assign last_slice = (idx_q == IW'(NCH - 1));
    assign accept     = in_valid && in_ready;

    popcount_slice #(.CHUNK(CHUNK)) u_slice (
        .data (slice),
        .cnt  (slice_cnt)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = COUNT;
            end
            COUNT: begin
                if (last_slice) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            target_q  <= '0;
            mode_q    <= MODE_EQ;
            acc_q     <= '0;
            idx_q     <= '0;
            out_count <= '0;
            out_match <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q   <= in_data;
                target_q <= in_target;
                mode_q   <= mode_e'(in_mode);
                acc_q    <= '0;
                idx_q    <= '0;
            end else if (state_q == COUNT) begin
                acc_q <= acc_next;
                idx_q <= idx_q + IW'(1);
                if (last_slice) begin
                    out_count <= acc_next;
                    out_match <= match_f(32'(acc_next), 32'(target_q), mode_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_matcher.sv
// tb/tb_popcount_matcher.sv - scoreboard bench for popcount_matcher
module tb_popcount_matcher;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [4:0]  in_target;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_count;
    logic        out_match;

    logic        d7_in_valid;
    logic        d7_in_ready;
    logic [6:0]  d7_in_data;
    logic [2:0]  d7_in_target;
    logic [1:0]  d7_in_mode;
    logic        d7_out_valid;
    logic        d7_out_ready;
    logic [2:0]  d7_out_count;
    logic        d7_out_match;

    popcount_matcher #(.W(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_target(in_target), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_match(out_match)
    );

    popcount_matcher #(.W(7), .CHUNK(7)) dut7 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d7_in_valid), .in_ready(d7_in_ready), .in_data(d7_in_data),
        .in_target(d7_in_target), .in_mode(d7_in_mode),
        .out_valid(d7_out_valid), .out_ready(d7_out_ready),
        .out_count(d7_out_count), .out_match(d7_out_match)
    );

    typedef struct {
        int   count;
        logic match;
        int   acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Offer a word and wait (bounded) for it to be taken; optionally register its expected result.
    task automatic send(input logic [15:0] data, input logic [4:0] target, input logic [1:0] mode,
                        input bit push, input int exp_count, input logic exp_match,
                        input bit hold_valid);
        exp_t e;
        int   t;
        in_valid  = 1'b1;
        in_data   = data;
        in_target = target;
        in_mode   = mode;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 100);
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (push) begin
            e.count   = exp_count;
            e.match   = exp_match;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        if (!hold_valid) in_valid = 1'b0;
    endtask

    // Monitor: compares each completed result against the head of the scoreboard.
    initial begin
        bit   prev_valid;
        bit   chk_ready;
        int   rise_cyc;
        exp_t e;
        prev_valid = 0;
        chk_ready  = 0;
        rise_cyc   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0;
                chk_ready  = 0;
            end else begin
                if (out_valid && !prev_valid) rise_cyc = cyc;
                prev_valid = out_valid;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_count", int'(out_count), e.count);
                        check("out_match", int'(out_match), int'(e.match));
                        check("latency", rise_cyc - e.acc_cyc, 4);
                        chk_ready = 1;
                    end
                end else if (chk_ready) begin
                    check("in_ready_after_handshake", int'(in_ready), 1);
                    chk_ready = 0;
                end
            end
        end
    end

    initial begin
        int t;
        int held_count;
        int acc7;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_target    = '0;
        in_mode      = '0;
        out_ready    = 1'b1;
        d7_in_valid  = 1'b0;
        d7_in_data   = '0;
        d7_in_target = '0;
        d7_in_mode   = '0;
        d7_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_count", int'(out_count), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(16'hFFFF, 5'd16, 2'b00, 1, 16, 1'b1, 0);
        send(16'h0000, 5'd0,  2'b10, 1, 0,  1'b1, 0);
        send(16'h0000, 5'd1,  2'b01, 1, 0,  1'b0, 0);
        send(16'h0000, 5'd0,  2'b11, 1, 0,  1'b0, 0);
        send(16'hA5A5, 5'd9,  2'b01, 1, 8,  1'b0, 0);
        send(16'hA5A5, 5'd9,  2'b10, 1, 8,  1'b1, 0);
        send(16'hA5A5, 5'd31, 2'b00, 1, 8,  1'b0, 0);
        send(16'hA5A5, 5'd0,  2'b11, 1, 8,  1'b0, 0);
        send(16'hA5A4, 5'd0,  2'b11, 1, 7,  1'b1, 0);
        send(16'hFFFF, 5'd17, 2'b01, 1, 16, 1'b0, 0);
        send(16'hFFFF, 5'd31, 2'b10, 1, 16, 1'b1, 0);

        // Back-pressure with a competing word held on the input.
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        out_ready = 1'b0;
        send(16'h0F0F, 5'd8, 2'b01, 1, 8, 1'b1, 1);
        in_data   = 16'h8001;
        in_target = 5'd1;
        in_mode   = 2'b10;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 50);
        check("bp_valid_rise", int'(out_valid), 1);
        held_count = int'(out_count);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_count", int'(out_count), held_count);
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h8001, 5'd1, 2'b10, 1, 2, 1'b0, 0);

        // Reset two cycles into COUNT aborts the word.
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        send(16'hFFFF, 5'd0, 2'b00, 0, 0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_match", int'(out_match), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_result", int'(out_valid), 0);
        send(16'h00F0, 5'd4, 2'b00, 1, 4, 1'b1, 0);

        // Single-chunk instance.
        d7_in_valid  = 1'b1;
        d7_in_data   = 7'b1011001;
        d7_in_target = 3'd4;
        d7_in_mode   = 2'b00;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!d7_in_ready && t < 50);
        @(posedge clk);
        #1;
        d7_in_valid = 1'b0;
        acc7 = cyc;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!d7_out_valid && t < 50);
        check("w7_valid", int'(d7_out_valid), 1);
        check("w7_latency", cyc - acc7, 1);
        check("w7_count", int'(d7_out_count), 4);
        check("w7_match", int'(d7_out_match), 1);

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
